// File: rtl/mod_exp_pkg.sv
// Shared types and helpers for the modular exponentiation engine.
// Latency: n/a (types and functions only).
// Backpressure: n/a.
package mod_exp_pkg;

    // Engine sequencing states.
    typedef enum logic [2:0] {
        IDLE     = 3'd0,
        REDUCE   = 3'd1,
        SQUARE   = 3'd2,
        MULTIPLY = 3'd3,
        DONE     = 3'd4
    } state_t;

    // Cycles from the accept edge to the valid edge for n > 1.
    // Every modular product costs width+1 cycles. There is one reduction,
    // one square per exponent bit, and one multiply per set bit. In
    // constant-time mode there is one multiply for every bit. One further
    // cycle is spent in DONE.
    function automatic int mod_exp_latency(input int width, input int exp_width,
                                           input int ones, input bit const_time);
        int n_ops;
        n_ops = 1 + exp_width + (const_time ? exp_width : ones);
        return (width + 1) * n_ops + 1;
    endfunction

endpackage

// File: rtl/mod_exp_engine_mod_mul.sv
// Bit-serial interleaved shift-add modular multiplier: p = a*b mod n (requires b < n).
// Latency: WIDTH+1 cycles per product (start/load cycle plus WIDTH iterations), then a one-cycle done pulse.
// Backpressure: none; a start pulse always reloads and restarts, abandoning any product in flight.
module mod_mul #(
    parameter int WIDTH = 16
) (
    input  logic             clk,
    input  logic             reset_n,
    input  logic             start,
    input  logic [WIDTH-1:0] a,
    input  logic [WIDTH-1:0] b,
    input  logic [WIDTH-1:0] n,
    output logic [WIDTH-1:0] p,
    output logic             done
);

    localparam int CW = $clog2(WIDTH);

    logic [WIDTH-1:0] a_sh;
    logic [WIDTH-1:0] b_q;
    logic [WIDTH-1:0] n_q;
    logic [WIDTH-1:0] p_q;
    logic [CW-1:0]    cnt;
    logic             active;
    logic [WIDTH:0]   p_dbl;
    logic [WIDTH:0]   p_add;
    logic [WIDTH-1:0] p_fin;

    // One iteration: double and reduce, then conditionally add b and reduce.
    // Both operands stay below n, so WIDTH+1 bits hold every intermediate value.
    always_comb begin
        p_dbl = {p_q, 1'b0};
        if (p_dbl >= {1'b0, n_q}) begin
            p_dbl = p_dbl - {1'b0, n_q};
        end
        p_add = p_dbl;
        if (a_sh[WIDTH-1]) begin
            p_add = p_dbl + {1'b0, b_q};
        end
        if (p_add >= {1'b0, n_q}) begin
            p_fin = WIDTH'(p_add - {1'b0, n_q});
        end else begin
            p_fin = p_add[WIDTH-1:0];
        end
    end

    // Load on start, then walk a MSB-first for WIDTH cycles and pulse done.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            a_sh   <= '0;
            b_q    <= '0;
            n_q    <= '0;
            p_q    <= '0;
            cnt    <= '0;
            active <= 1'b0;
            done   <= 1'b0;
        end else begin
            done <= 1'b0;
            if (start) begin
                a_sh   <= a;
                b_q    <= b;
                n_q    <= n;
                p_q    <= '0;
                cnt    <= CW'(WIDTH - 1);
                active <= 1'b1;
            end else if (active) begin
                p_q  <= p_fin;
                a_sh <= a_sh << 1;
                if (cnt == '0) begin
                    active <= 1'b0;
                    done   <= 1'b1;
                end else begin
                    cnt <= cnt - 1'b1;
                end
            end
        end
    end

    assign p = p_q;

endmodule

// File: rtl/mod_exp_engine.sv
// Left-to-right square-and-multiply engine: result = m^e mod n (optional macro MOD_EXP_CONST_TIME_EN).
// Latency: (WIDTH+1)*(1+EXP_WIDTH+popcount(e))+1 cycles after accept (constant-time mode: (WIDTH+1)*(1+2*EXP_WIDTH)+1); n<2 takes 2 cycles.
// Backpressure: ready is accepted only in IDLE; requests while busy or in DONE are dropped, with no queuing.
module mod_exp_engine
    import mod_exp_pkg::*;
#(
    parameter int WIDTH     = 16,
    parameter int EXP_WIDTH = WIDTH
) (
    input  logic                 clk,
    input  logic                 reset_n,
    input  logic [WIDTH-1:0]     m,
    input  logic [EXP_WIDTH-1:0] e,
    input  logic [WIDTH-1:0]     n,
    input  logic                 ready,
    output logic                 busy,
    output logic [WIDTH-1:0]     result,
    output logic                 valid,
    output logic                 err
);

    localparam int IW = (EXP_WIDTH > 1) ? $clog2(EXP_WIDTH) : 1;

    state_t               state;
    logic [EXP_WIDTH-1:0] e_q;
    logic [WIDTH-1:0]     n_q;
    logic [WIDTH-1:0]     base;
    logic [WIDTH-1:0]     acc;
    logic [IW-1:0]        idx;
`ifdef MOD_EXP_CONST_TIME_EN
    logic [WIDTH-1:0]     discard;
`endif

    logic                 bit_set;
    logic                 do_mul;
    logic [WIDTH-1:0]     acc_nxt;
    logic                 mm_start;
    logic [WIDTH-1:0]     mm_a;
    logic [WIDTH-1:0]     mm_b;
    logic [WIDTH-1:0]     mm_n;
    logic [WIDTH-1:0]     mm_p;
    logic                 mm_done;

    // The next product launches in the same cycle that the previous one reports
    // done. Its operands therefore come from the accumulator value that is being
    // written on that edge. The reduction launches directly in the accept cycle,
    // using the input ports. The multiplier keeps its own copy of m, so m needs
    // no separate register here.
    always_comb begin
        bit_set = e_q[idx];
`ifdef MOD_EXP_CONST_TIME_EN
        do_mul  = 1'b1;
`else
        do_mul  = bit_set;
`endif
        acc_nxt  = acc;
        mm_start = 1'b0;
        mm_n     = n_q;
        case (state)
            IDLE: begin
                mm_start = ready && (n > WIDTH'(1));
                mm_n     = n;
            end
            REDUCE: begin
                acc_nxt  = WIDTH'(1);
                mm_start = mm_done && (n_q > WIDTH'(1));
            end
            SQUARE: begin
                if (mm_done) begin
                    acc_nxt  = mm_p;
                    mm_start = do_mul || (idx != '0);
                end
            end
            MULTIPLY: begin
                if (mm_done) begin
                    acc_nxt  = bit_set ? mm_p : acc;
                    mm_start = (idx != '0);
                end
            end
            default: begin
                acc_nxt = acc;
            end
        endcase
        mm_a = acc_nxt;
        mm_b = acc_nxt;
        if (state == IDLE) begin
            mm_a = m;
            mm_b = WIDTH'(1);
        end else if ((state == SQUARE) && do_mul) begin
            mm_b = base;
        end
    end

    mod_mul #(
        .WIDTH (WIDTH)
    ) u_mod_mul (
        .clk     (clk),
        .reset_n (reset_n),
        .start   (mm_start),
        .a       (mm_a),
        .b       (mm_b),
        .n       (mm_n),
        .p       (mm_p),
        .done    (mm_done)
    );

    // Sequencer: accept, reduce the base, square/multiply per exponent bit, publish.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            state  <= IDLE;
            e_q    <= '0;
            n_q    <= '0;
            base   <= '0;
            acc    <= '0;
            idx    <= '0;
            busy   <= 1'b0;
            result <= '0;
            valid  <= 1'b0;
            err    <= 1'b0;
`ifdef MOD_EXP_CONST_TIME_EN
            discard <= '0;
`endif
        end else begin
            valid <= 1'b0;
            case (state)
                IDLE: begin
                    if (ready) begin
                        e_q   <= e;
                        n_q   <= n;
                        busy  <= 1'b1;
                        err   <= 1'b0;
                        state <= REDUCE;
                    end
                end
                REDUCE: begin
                    if (n_q <= WIDTH'(1)) begin
                        // Degenerate modulus: the answer is always 0.
                        acc   <= '0;
                        state <= DONE;
                    end else if (mm_done) begin
                        base  <= mm_p;
                        acc   <= acc_nxt;
                        idx   <= IW'(EXP_WIDTH - 1);
                        state <= SQUARE;
                    end
                end
                SQUARE: begin
                    if (mm_done) begin
                        acc <= acc_nxt;
                        if (do_mul) begin
                            state <= MULTIPLY;
                        end else if (idx == '0) begin
                            state <= DONE;
                        end else begin
                            idx <= idx - 1'b1;
                        end
                    end
                end
                MULTIPLY: begin
                    if (mm_done) begin
                        acc <= acc_nxt;
`ifdef MOD_EXP_CONST_TIME_EN
                        if (!bit_set) begin
                            discard <= mm_p;
                        end
`endif
                        if (idx == '0) begin
                            state <= DONE;
                        end else begin
                            idx   <= idx - 1'b1;
                            state <= SQUARE;
                        end
                    end
                end
                DONE: begin
                    result <= acc;
                    valid  <= 1'b1;
                    err    <= (n_q == '0);
                    busy   <= 1'b0;
                    state  <= IDLE;
                end
                default: begin
                    state <= IDLE;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_mod_exp_engine.sv
// Directed and reference-checked bench for mod_exp_engine at WIDTH=16.
// Latency: measured from the accept edge to the first edge showing valid.
// Backpressure: exercises requests that arrive while the engine is busy (they must be dropped).
module tb_mod_exp_engine;

    logic        clk;
    logic        reset_n;
    logic [15:0] m;
    logic [15:0] e;
    logic [15:0] n;
    logic        ready;
    logic        busy;
    logic [15:0] result;
    logic        valid;
    logic        err;

    int checks = 0;
    int errors = 0;

    mod_exp_engine #(
        .WIDTH     (16),
        .EXP_WIDTH (16)
    ) dut (
        .clk     (clk),
        .reset_n (reset_n),
        .m       (m),
        .e       (e),
        .n       (n),
        .ready   (ready),
        .busy    (busy),
        .result  (result),
        .valid   (valid),
        .err     (err)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s: got %0d expected %0d", tag, got, exp);
        end
    endtask

    // Expected latency for n > 1, derived from the operation count.
    function automatic int lat_of(input logic [15:0] ev);
        int ones;
        ones = 0;
        for (int i = 0; i < 16; i++) begin
            if (ev[i]) ones++;
        end
`ifdef MOD_EXP_CONST_TIME_EN
        ones = 16;
`endif
        return 17 * (1 + 16 + ones) + 1;
    endfunction

    // Independent reference: left-to-right square-and-multiply using wide integers.
    function automatic logic [15:0] ref_modexp(input logic [15:0] mv, input logic [15:0] ev,
                                              input logic [15:0] nv);
        longint r;
        longint b;
        if (nv < 16'd2) return 16'd0;
        b = longint'(mv) % longint'(nv);
        r = 1;
        for (int i = 15; i >= 0; i--) begin
            r = (r * r) % longint'(nv);
            if (ev[i]) r = (r * b) % longint'(nv);
        end
        return 16'(r);
    endfunction

    // Called #1 after a clock edge; returns #1 after the edge on which valid appears.
    task automatic run_op(input string tag, input logic [15:0] mi, input logic [15:0] ei,
                          input logic [15:0] ni, input logic [15:0] exp_res,
                          input logic exp_err, input int exp_lat);
        int lat;
        m     = mi;
        e     = ei;
        n     = ni;
        ready = 1'b1;
        @(posedge clk);
        #1;
        ready = 1'b0;
        chk({tag, "_busy_hi"}, 32'(busy), 32'd1);
        lat = 0;
        do begin
            @(posedge clk);
            lat++;
            #1;
        end while (!valid && lat < 4000);
        chk({tag, "_valid"}, 32'(valid), 32'd1);
        chk({tag, "_lat"}, 32'(lat), 32'(exp_lat));
        chk({tag, "_result"}, 32'(result), 32'(exp_res));
        chk({tag, "_err"}, 32'(err), 32'(exp_err));
        chk({tag, "_busy_lo"}, 32'(busy), 32'd0);
    endtask

    initial begin
        int pulses;
        int vlat;
        logic [15:0] vres;
        logic [15:0] rm;
        logic [15:0] re;
        logic [15:0] rn;

        reset_n = 1'b0;
        ready   = 1'b0;
        m       = '0;
        e       = '0;
        n       = '0;
        repeat (3) @(posedge clk);
        #1;
        chk("rst_busy", 32'(busy), 32'd0);
        chk("rst_valid", 32'(valid), 32'd0);
        chk("rst_err", 32'(err), 32'd0);
        chk("rst_result", 32'(result), 32'd0);
        reset_n = 1'b1;
        @(posedge clk);
        #1;

        // Directed vectors with hand-computed answers.
        run_op("v12_56_99", 16'd12, 16'd56, 16'd99, 16'd45, 1'b0, lat_of(16'd56));
        run_op("v4_13_497", 16'd4, 16'd13, 16'd497, 16'd445, 1'b0, lat_of(16'd13));
        run_op("v200_1_99", 16'd200, 16'd1, 16'd99, 16'd2, 1'b0, lat_of(16'd1));
        run_op("e0", 16'd5, 16'd0, 16'd99, 16'd1, 1'b0, lat_of(16'd0));
        run_op("n1", 16'd7, 16'd9, 16'd1, 16'd0, 1'b0, 2);
        run_op("n0", 16'd7, 16'd9, 16'd0, 16'd0, 1'b1, 2);
        // err must clear on the next accepted request.
        run_op("after_n0", 16'd3, 16'd4, 16'd10, 16'd1, 1'b0, lat_of(16'd4));

        // A request arriving mid-computation is dropped; exactly one valid appears.
        m     = 16'd12;
        e     = 16'd56;
        n     = 16'd99;
        ready = 1'b1;
        @(posedge clk);
        #1;
        ready  = 1'b0;
        pulses = 0;
        vlat   = 0;
        vres   = '0;
        for (int k = 1; k <= 700; k++) begin
            @(posedge clk);
            #1;
            if (k == 20) begin
                m     = 16'd7;
                e     = 16'd3;
                n     = 16'd11;
                ready = 1'b1;
            end else if (k == 21) begin
                ready = 1'b0;
            end
            if (valid) begin
                pulses++;
                vlat = k;
                vres = result;
            end
        end
        chk("busy_ign_pulses", 32'(pulses), 32'd1);
        chk("busy_ign_lat", 32'(vlat), 32'(lat_of(16'd56)));
        chk("busy_ign_result", 32'(vres), 32'd45);

        // Reset in the middle of the square/multiply loop aborts immediately.
        m     = 16'd3;
        e     = 16'hffff;
        n     = 16'd1000;
        ready = 1'b1;
        @(posedge clk);
        #1;
        ready = 1'b0;
        repeat (40) @(posedge clk);
        #1;
        chk("mid_busy_before", 32'(busy), 32'd1);
        reset_n = 1'b0;
        #1;
        chk("mid_rst_busy", 32'(busy), 32'd0);
        chk("mid_rst_valid", 32'(valid), 32'd0);
        chk("mid_rst_result", 32'(result), 32'd0);
        chk("mid_rst_err", 32'(err), 32'd0);
        pulses = 0;
        for (int k = 0; k < 5; k++) begin
            @(posedge clk);
            #1;
            if (valid) pulses++;
        end
        chk("mid_rst_no_valid", 32'(pulses), 32'd0);
        reset_n = 1'b1;
        @(posedge clk);
        #1;
        run_op("restart", 16'd12, 16'd56, 16'd99, 16'd45, 1'b0, lat_of(16'd56));

        // Back-to-back random requests against the reference model.
        for (int r = 0; r < 6; r++) begin
            rm = 16'($urandom);
            re = 16'($urandom);
            rn = 16'($urandom_range(65535, 2));
            run_op($sformatf("rnd%0d", r), rm, re, rn, ref_modexp(rm, re, rn), 1'b0, lat_of(re));
        end

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
